// File: rtl/vt52_pkg.sv
// rtl/vt52_pkg.sv - screen geometry, byte codes, FSM encoding and cell-address helpers
// Shared by command_handler and buffer_filler; no ports.
package vt52_pkg;

    localparam int ROWS      = 24;
    localparam int COLS      = 80;
    localparam int ROW_BITS  = 5;
    localparam int COL_BITS  = 7;
    localparam int ADDR_BITS = 11;
    localparam int CELLS     = ROWS * COLS;
    // One extra bit so first_char + offset (max 3838) never overflows before wrapping.
    localparam int SUM_BITS  = ADDR_BITS + 1;

    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(CELLS - 1);
    localparam logic [ADDR_BITS-1:0] CELLS_A   = ADDR_BITS'(CELLS);
    localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
    localparam logic [SUM_BITS-1:0]  CELLS_W   = SUM_BITS'(CELLS);
    localparam logic [7:0]           ROWS_B    = 8'(ROWS);
    localparam logic [7:0]           COLS_B    = 8'(COLS);

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_ESC   = 8'h1B;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_TILDE = 8'h7E;

    localparam logic [7:0] ESC_UP    = 8'h41;  // 'A'
    localparam logic [7:0] ESC_DOWN  = 8'h42;  // 'B'
    localparam logic [7:0] ESC_RIGHT = 8'h43;  // 'C'
    localparam logic [7:0] ESC_LEFT  = 8'h44;  // 'D'
    localparam logic [7:0] ESC_HOME  = 8'h48;  // 'H'
    localparam logic [7:0] ESC_EOS   = 8'h4A;  // 'J' clear to end of screen
    localparam logic [7:0] ESC_EOL   = 8'h4B;  // 'K' clear to end of line
    localparam logic [7:0] ESC_ADDR  = 8'h59;  // 'Y' direct cursor address

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_Y_ROW,
        ST_Y_COL,
        ST_FILL
    } state_t;

    function automatic logic [ADDR_BITS-1:0] wrap_cell(input logic [SUM_BITS-1:0] v);
        logic [SUM_BITS-1:0] r;
        r = (v >= CELLS_W) ? v - CELLS_W : v;
        return r[ADDR_BITS-1:0];
    endfunction

    function automatic logic [SUM_BITS-1:0] cell_offset(input logic [ROW_BITS-1:0] y,
                                                        input logic [COL_BITS-1:0] x);
        return SUM_BITS'(y) * SUM_BITS'(COLS) + SUM_BITS'(x);
    endfunction

    function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [ADDR_BITS-1:0] fc,
                                                       input logic [ROW_BITS-1:0]  y,
                                                       input logic [COL_BITS-1:0]  x);
        return wrap_cell(SUM_BITS'(fc) + cell_offset(y, x));
    endfunction

    function automatic logic [ADDR_BITS-1:0] next_cell(input logic [ADDR_BITS-1:0] a);
        return (a == LAST_CELL) ? '0 : a + ADDR_BITS'(1);
    endfunction

endpackage

// File: rtl/buffer_filler.sv
// rtl/buffer_filler.sv - char-buffer write port: runs count writes at consecutive wrapping addresses
// Ports: clk, clr_n (async active-low); start/start_addr/count load a run;
//        waddr/wen are the registered write port; done flags the last write of the run.
module buffer_filler
    import vt52_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS-1:0] count,
    output logic [ADDR_BITS-1:0] waddr,
    output logic                 wen,
    output logic                 done
);

    logic [ADDR_BITS-1:0] remaining;  // writes still to go after the current one

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            waddr     <= '0;
            wen       <= 1'b0;
            remaining <= '0;
        end else if (start) begin
            // A new run may start on the last cycle of the previous one.
            waddr     <= start_addr;
            wen       <= 1'b1;
            remaining <= count - ADDR_BITS'(1);
        end else if (wen) begin
            if (remaining == '0) begin
                wen <= 1'b0;
            end else begin
                waddr     <= next_cell(waddr);
                remaining <= remaining - ADDR_BITS'(1);
            end
        end
    end

    assign done = wen && (remaining == '0);

endmodule

// File: rtl/command_handler.sv
// rtl/command_handler.sv - VT52-style byte interpreter driving the char buffer and cursor
// Ports: clk, clr_n (async active-low); data_in/data_valid/data_ready byte input;
//        buffer_waddr/buffer_din/buffer_wen cell writes; buffer_first_char(+_wen) scroll origin;
//        new_cursor_x/new_cursor_y(+_wen) cursor position. All outputs registered.
module command_handler
    import vt52_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen,
    output logic [COL_BITS-1:0]  new_cursor_x,
    output logic [ROW_BITS-1:0]  new_cursor_y,
    output logic                 new_cursor_wen
);

    state_t               state_q, state_d;
    logic                 init_q;      // first cycle out of reset: clear the screen
    logic [7:0]           row_q, row_d;
    logic                 accept;
    logic [7:0]           arg;
    logic [COL_BITS-1:0]  x_d;
    logic [ROW_BITS-1:0]  y_d;
    logic [ADDR_BITS-1:0] fc_d;
    logic                 fc_wen_d;
    logic [7:0]           din_d;
    logic                 fill_start;
    logic [ADDR_BITS-1:0] fill_addr, fill_count;
    logic                 fill_done;
    logic [SUM_BITS-1:0]  offset, remain_screen;
    logic [ADDR_BITS-1:0] cursor_cell;

    assign accept        = data_valid && data_ready;
    assign arg           = data_in - CHAR_SPACE;
    assign offset        = cell_offset(new_cursor_y, new_cursor_x);
    assign remain_screen = CELLS_W - offset;
    assign cursor_cell   = cell_addr(buffer_first_char, new_cursor_y, new_cursor_x);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (init_q) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    if (data_in == CHAR_ESC)
                        state_d = ST_ESC;
                    else if (data_in == CHAR_LF && new_cursor_y == LAST_ROW)
                        state_d = ST_FILL;
                end
                ST_ESC: if (accept) begin
                    case (data_in)
                        ESC_EOS, ESC_EOL: state_d = ST_FILL;
                        ESC_ADDR:         state_d = ST_Y_ROW;
                        default:          state_d = ST_IDLE;
                    endcase
                end
                ST_Y_ROW: if (accept) state_d = ST_Y_COL;
                ST_Y_COL: if (accept) state_d = ST_IDLE;
                ST_FILL:  if (fill_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs. Printable bytes reuse the filler as a
    // one-cell run so the write port has a single registered source.
    always_comb begin
        x_d        = new_cursor_x;
        y_d        = new_cursor_y;
        fc_d       = buffer_first_char;
        fc_wen_d   = 1'b0;
        din_d      = buffer_din;
        row_d      = row_q;
        fill_start = 1'b0;
        fill_addr  = cursor_cell;
        fill_count = ADDR_BITS'(1);
        if (init_q) begin
            fill_start = 1'b1;
            fill_addr  = '0;
            fill_count = CELLS_A;
            din_d      = CHAR_SPACE;
            fc_wen_d   = 1'b1;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_in >= CHAR_SPACE && data_in <= CHAR_TILDE) begin
                        fill_start = 1'b1;
                        din_d      = data_in;
                        if (new_cursor_x != LAST_COL) x_d = new_cursor_x + COL_BITS'(1);
                    end else if (data_in == CHAR_CR) begin
                        x_d = '0;
                    end else if (data_in == CHAR_BS) begin
                        if (new_cursor_x != '0) x_d = new_cursor_x - COL_BITS'(1);
                    end else if (data_in == CHAR_LF) begin
                        if (new_cursor_y != LAST_ROW) begin
                            y_d = new_cursor_y + ROW_BITS'(1);
                        end else begin
                            // Scroll: old top row becomes the new bottom row, blanked.
                            fc_d       = wrap_cell(SUM_BITS'(buffer_first_char) + SUM_BITS'(COLS));
                            fc_wen_d   = 1'b1;
                            fill_start = 1'b1;
                            fill_addr  = buffer_first_char;
                            fill_count = COLS_A;
                            din_d      = CHAR_SPACE;
                        end
                    end
                end
                ST_ESC: begin
                    case (data_in)
                        ESC_UP:    if (new_cursor_y != '0) y_d = new_cursor_y - ROW_BITS'(1);
                        ESC_DOWN:  if (new_cursor_y != LAST_ROW) y_d = new_cursor_y + ROW_BITS'(1);
                        ESC_RIGHT: if (new_cursor_x != LAST_COL) x_d = new_cursor_x + COL_BITS'(1);
                        ESC_LEFT:  if (new_cursor_x != '0) x_d = new_cursor_x - COL_BITS'(1);
                        ESC_HOME: begin
                            x_d = '0;
                            y_d = '0;
                        end
                        ESC_EOS: begin
                            fill_start = 1'b1;
                            fill_count = remain_screen[ADDR_BITS-1:0];
                            din_d      = CHAR_SPACE;
                        end
                        ESC_EOL: begin
                            fill_start = 1'b1;
                            fill_count = COLS_A - ADDR_BITS'(new_cursor_x);
                            din_d      = CHAR_SPACE;
                        end
                        default: ;
                    endcase
                end
                ST_Y_ROW: row_d = arg;
                ST_Y_COL: begin
                    if (row_q < ROWS_B) y_d = row_q[ROW_BITS-1:0];
                    x_d = (arg < COLS_B) ? arg[COL_BITS-1:0] : LAST_COL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            init_q                <= 1'b1;
            row_q                 <= '0;
            new_cursor_x          <= '0;
            new_cursor_y          <= '0;
            new_cursor_wen        <= 1'b0;
            buffer_first_char     <= '0;
            buffer_first_char_wen <= 1'b0;
            buffer_din            <= '0;
            data_ready            <= 1'b0;
        end else begin
            init_q                <= 1'b0;
            row_q                 <= row_d;
            new_cursor_x          <= x_d;
            new_cursor_y          <= y_d;
            new_cursor_wen        <= (x_d != new_cursor_x) || (y_d != new_cursor_y);
            buffer_first_char     <= fc_d;
            buffer_first_char_wen <= fc_wen_d;
            buffer_din            <= din_d;
            data_ready            <= (state_d != ST_FILL);
        end
    end

    buffer_filler u_filler (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (fill_start),
        .start_addr (fill_addr),
        .count      (fill_count),
        .waddr      (buffer_waddr),
        .wen        (buffer_wen),
        .done       (fill_done)
    );

endmodule

// File: tb/tb_command_handler.sv
// tb/tb_command_handler.sv - randomized self-checking bench for command_handler with a screen model
module tb_command_handler;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;
    logic [6:0]  new_cursor_x;
    logic [4:0]  new_cursor_y;
    logic        new_cursor_wen;

    command_handler dut (
        .clk                   (clk),
        .clr_n                 (clr_n),
        .data_in               (data_in),
        .data_valid            (data_valid),
        .data_ready            (data_ready),
        .buffer_waddr          (buffer_waddr),
        .buffer_din            (buffer_din),
        .buffer_wen            (buffer_wen),
        .buffer_first_char     (buffer_first_char),
        .buffer_first_char_wen (buffer_first_char_wen),
        .new_cursor_x          (new_cursor_x),
        .new_cursor_y          (new_cursor_y),
        .new_cursor_wen        (new_cursor_wen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Observed activity, appended only by this monitor.
    int act_w[$];
    int act_c[$];
    int act_fc[$];
    int act_cur[$];
    int cyc     = 0;
    int low_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (buffer_wen) begin
            act_w.push_back(int'({buffer_waddr, buffer_din}));
            act_c.push_back(cyc);
        end
        if (buffer_first_char_wen) act_fc.push_back(int'(buffer_first_char));
        if (new_cursor_wen) act_cur.push_back(int'({new_cursor_x, new_cursor_y}));
        if (!data_ready) low_cnt <= low_cnt + 1;
    end

    // Screen model: linear cursor position, scroll origin, escape parse mode.
    int mx, my, mfc, mmode, mrow;
    int exp_w[$];
    int exp_fc[$];
    int exp_cur[$];
    int exp_low;
    int w_base, fc_base, cur_base, low_base;

    function automatic void push_fill(input int lin, input int n);
        for (int k = 0; k < n; k++) exp_w.push_back(((mfc + lin + k) % 1920) * 256 + 32);
        exp_low = n;
    endfunction

    function automatic void model_byte(input int b);
        int ox = mx;
        int oy = my;
        int c;
        case (mmode)
            0: begin
                if (b >= 32 && b <= 126) begin
                    exp_w.push_back(((mfc + my * 80 + mx) % 1920) * 256 + b);
                    if (mx < 79) mx++;
                end else if (b == 13) mx = 0;
                else if (b == 8) begin if (mx > 0) mx--; end
                else if (b == 10) begin
                    if (my < 23) my++;
                    else begin
                        push_fill(0, 80);
                        mfc = (mfc + 80) % 1920;
                        exp_fc.push_back(mfc);
                    end
                end else if (b == 27) mmode = 1;
            end
            1: begin
                mmode = 0;
                case (b)
                    65: if (my > 0) my--;
                    66: if (my < 23) my++;
                    67: if (mx < 79) mx++;
                    68: if (mx > 0) mx--;
                    72: begin mx = 0; my = 0; end
                    74: push_fill(my * 80 + mx, 1920 - (my * 80 + mx));
                    75: push_fill(my * 80 + mx, 80 - mx);
                    89: mmode = 2;
                    default: ;
                endcase
            end
            2: begin
                mrow  = (b - 32) & 255;
                mmode = 3;
            end
            default: begin
                c = (b - 32) & 255;
                if (mrow < 24) my = mrow;
                mx    = (c < 80) ? c : 79;
                mmode = 0;
            end
        endcase
        if (mx != ox || my != oy) exp_cur.push_back(mx * 32 + my);
    endfunction

    task automatic start_batch();
        exp_w.delete();
        exp_fc.delete();
        exp_cur.delete();
        exp_low  = 0;
        w_base   = act_w.size();
        fc_base  = act_fc.size();
        cur_base = act_cur.size();
        low_base = low_cnt;
    endtask

    task automatic cmp_q(input string tag, input int act[$], input int base, input int exp[$]);
        int n = act.size() - base;
        int m;
        int idx = 0;
        check_eq({tag, "_count"}, n, exp.size());
        m = (n < exp.size()) ? n : exp.size();
        while (idx < m && act[base + idx] == exp[idx]) idx++;
        if (m > 0) begin
            if (idx == m) idx = m - 1;
            check_eq({tag, "_value"}, act[base + idx], exp[idx]);
        end
    endtask

    task automatic compare_batch(input string tag);
        int n = act_w.size() - w_base;
        int gaps = 0;
        cmp_q({tag, "/wr"}, act_w, w_base, exp_w);
        for (int i = 1; i < n; i++)
            if (act_c[w_base + i] != act_c[w_base + i - 1] + 1) gaps++;
        if (n > 1) check_eq({tag, "/wr_gaps"}, gaps, 0);
        cmp_q({tag, "/fc_strobe"}, act_fc, fc_base, exp_fc);
        cmp_q({tag, "/cur_strobe"}, act_cur, cur_base, exp_cur);
        check_eq({tag, "/ready_low"}, low_cnt - low_base, exp_low);
        check_eq({tag, "/x"}, new_cursor_x, mx);
        check_eq({tag, "/y"}, new_cursor_y, my);
        check_eq({tag, "/first_char"}, buffer_first_char, mfc);
    endtask

    task automatic settle();
        int g = 0;
        @(negedge clk);
        while (!data_ready && g < 2500) begin
            @(negedge clk);
            g++;
        end
        #1;
        if (!data_ready) check_eq("settle_timeout", data_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        while (!data_ready && g < 2500) begin
            @(negedge clk);
            g++;
        end
        if (!data_ready) check_eq("ready_timeout", data_ready, 1);
        start_batch();
        model_byte(int'(b));
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        settle();
        compare_batch($sformatf("byte_%02h", b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "/data_ready"}, data_ready, 0);
        check_eq({tag, "/waddr"}, buffer_waddr, 0);
        check_eq({tag, "/din"}, buffer_din, 0);
        check_eq({tag, "/wen"}, buffer_wen, 0);
        check_eq({tag, "/first_char"}, buffer_first_char, 0);
        check_eq({tag, "/first_char_wen"}, buffer_first_char_wen, 0);
        check_eq({tag, "/x"}, new_cursor_x, 0);
        check_eq({tag, "/y"}, new_cursor_y, 0);
        check_eq({tag, "/cursor_wen"}, new_cursor_wen, 0);
    endtask

    task automatic release_and_init(input string tag);
        @(negedge clk);
        #1 clr_n = 1'b1;
        mx = 0; my = 0; mfc = 0; mmode = 0; mrow = 0;
        start_batch();
        push_fill(0, 1920);
        exp_fc.push_back(0);
        settle();
        compare_batch(tag);
    endtask

    logic [7:0] esc_letters [0:8];

    initial begin
        #900000;
        $display("FAIL watchdog: time limit 900000 reached without finishing");
        $fatal(1);
    end

    initial begin
        int w0;
        esc_letters = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h4A, 8'h4B, 8'h59, 8'h5A};
        clr_n      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");

        release_and_init("init");

        send_byte(8'h41);
        send_byte(8'h42);
        check_eq("AB_x", new_cursor_x, 2);

        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h37); send_byte(8'h41);
        check_eq("Y_x", new_cursor_x, 33);
        check_eq("Y_y", new_cursor_y, 23);

        send_byte(8'h0A);
        check_eq("scroll1_fc", buffer_first_char, 80);

        for (int i = 0; i < 22; i++) send_byte(8'h0A);
        check_eq("scroll23_fc", buffer_first_char, 1840);

        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h21); send_byte(8'h25);
        send_byte(8'h1B); send_byte(8'h4B);

        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h50); send_byte(8'h70);
        check_eq("Yoor_x", new_cursor_x, 79);
        check_eq("Yoor_y", new_cursor_y, 1);

        send_byte(8'h1B); send_byte(8'h5A);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0, 1: send_byte(8'($urandom_range(32, 126)));
                2: send_byte(8'h0D);
                3: send_byte(8'h08);
                4: send_byte(8'h0A);
                5: begin
                    send_byte(8'h1B);
                    send_byte(esc_letters[$urandom_range(0, 8)]);
                end
                6: begin
                    send_byte(8'h1B);
                    send_byte(8'h59);
                    send_byte(8'($urandom_range(0, 255)));
                    send_byte(8'($urandom_range(0, 255)));
                end
                default: send_byte(8'($urandom_range(0, 31)));
            endcase
        end

        // Abort a clear-to-end-of-screen fill with reset in its 10th write cycle.
        send_byte(8'h0D);
        send_byte(8'h1B); send_byte(8'h48);
        send_byte(8'h1B);
        @(negedge clk);
        w0 = act_w.size();
        data_in    = 8'h4A;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 clr_n = 1'b0;
        #1 check_reset_outputs("abort");
        check_eq("abort_writes", act_w.size() - w0, 10);
        repeat (4) @(negedge clk);
        #1 check_eq("abort_no_more_writes", act_w.size() - w0, 10);

        release_and_init("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
